count_bcd_display: RTL and testbench
====================================

// Module: count_bcd_display
// PURPOSE
//   Downstream consumer of the free-running counter. Snapshots the counter value on request and
//   converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
//   Drives a time-multiplexed seven-segment display showing the last converted value.
//   Sits between the counter output bus and the uo_out/uio_out pins.
// PARAMETERS
//   IN_W      16  width of count_in, the low bits of the counter; must satisfy 2^IN_W <= 10^DIGITS
//   DIGITS    5   number of BCD digits / display positions
//   SCAN_DIV  10  prescaler width; digit advances every 2^SCAN_DIV clk cycles
// PORTS
//   clk        in   1           clock, all state on rising edge
//   rst_n      in   1           asynchronous reset, active-HIGH (rst_n=1 resets)
//   count_in   in   IN_W        counter value to snapshot
//   load       in   1           conversion request, sampled each edge
//   busy       out  1           conversion in progress
//   bcd_valid  out  1           one-cycle pulse: new result committed
//   bcd_out    out  4*DIGITS    committed BCD result, digit 0 = LS nibble
//   seg        out  7           segments gfedcba, active-high
//   digit_sel  out  DIGITS      one-hot digit enable, active-high
// BEHAVIOUR
//   Reset values: busy=0, bcd_valid=0, bcd_out=0, scan index=0, prescaler=0.
//   Reset values (cont.): digit_sel=1, seg=7'h3F.
//   All outputs are registered. Reset mid-conversion aborts it; the result is discarded.
//   FSM IDLE -> CONVERT -> DONE -> IDLE.
//   IDLE/DONE: load=1 at edge k captures count_in and clears the scratch BCD; state becomes CONVERT.
//   CONVERT: one shift per edge (add 3 to each nibble >=5, then shift left 1).
//   CONVERT (cont.): edges k+1..k+IN_W; edge k+IN_W commits scratch to bcd_out; state becomes DONE.
//   busy=1 in CONVERT only. bcd_valid=1 exactly during DONE, i.e. the cycle after edge k+IN_W.
//   DONE: returns to IDLE next edge, or to CONVERT if load=1 (back-to-back allowed).
//   load while busy=1: ignored, no queueing. bcd_out holds its value until the next commit.
//   Scanner runs independently of the FSM.
//   Prescaler wraps 2^SCAN_DIV-1 -> 0; on wrap, index advances and wraps DIGITS-1 -> 0.
//   digit_sel and seg update on the same edge.
//   seg shows the nibble of bcd_out at the current index (0-9 standard glyphs).
//   A commit in the same cycle as a digit advance: the new digit shows the new value. No mixed frame is required.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     seg=0 for any digit above the most significant nonzero digit.
//     Digit 0 is never blanked, so value 0 shows a single "0".
//   LEADING_ZERO_BLANK_EN undefined: every digit shows its glyph, including leading "0"=7'h3F.
//   digit_sel is unaffected either way.
// STRUCTURE
//   Package count_disp_pkg holds:
//     - FSM state encoding: IDLE, CONVERT, DONE.
//     - Seven-segment glyph constants SEG_0..SEG_9 and SEG_BLANK.
//     - Function bcd_add3(nibble).
//   Sub-module bcd_double_dabble (params IN_W, DIGITS) contains:
//     - FSM, shift register, shift counter; outputs busy, bcd_valid, bcd_out.
//   Top level contains the prescaler, scan index, glyph mux and blanking.
// TESTING (SCAN_DIV=4 in sim)
//   1. Reset asserted, then released:
//      seg=7'h3F, digit_sel=5'b00001, busy=0, bcd_valid=0, bcd_out=0.
//   2. count_in=12345, load pulsed at edge k:
//      busy high for 16 cycles; bcd_valid is a single pulse after edge k+16; bcd_out=20'h12345.
//      Scan shows 5,4,3,2,1 on digit_sel bits 0..4, each held 16 cycles.
//   3. Boundaries:
//      count_in=65535 -> bcd_out=20'h65535; count_in=0 -> bcd_out=0.
//      Back-to-back load in DONE is accepted.
//   4. Load 100, then load 999 while busy at cycle k+5:
//      999 is ignored; bcd_out=20'h00100; exactly one bcd_valid pulse.
//   5. Reset asserted at cycle k+8 of a conversion:
//      all outputs return to reset values; a new load of 7 yields bcd_out=7.
//   6. count_in=42:
//      with LEADING_ZERO_BLANK_EN, digits 2-4 give seg=0;
//      without it, those digits give seg=7'h3F. Digits 0/1 show 2/4 in both builds.

Source files
------------

// File: rtl/count_disp_pkg.sv
// Shared types and helpers for the BCD counter display: FSM encoding,
// seven-segment glyphs (gfedcba, active-high) and the double-dabble add-3 step.
package count_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } dd_state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // Non-decimal nibbles cannot occur in a committed result; show them dark.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock, IN_W steps
// per conversion; loads while busy are dropped.
module bcd_double_dabble
  import count_disp_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       count_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [4*DIGITS-1:0]   bcd_next_c
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  dd_state_t          r_state;
  dd_state_t          w_state_next;
  logic               w_accept;
  logic               w_commit;
  logic [IN_W-1:0]    r_bin;
  logic [BCD_W-1:0]   r_scratch;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_valid;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_shifted;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_next = CONVERT;
          w_accept     = 1'b1;
        end
      end
      CONVERT: begin
        if (r_cnt == CNT_W'(IN_W - 1)) begin
          w_state_next = DONE;
          w_commit     = 1'b1;
        end
      end
      DONE: begin
        if (load) begin
          w_state_next = CONVERT;
          w_accept     = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Add-3 correction on every nibble, then shift in the next binary MSB.
  always_comb begin
    w_adj = '0;
    for (int j = 0; j < int'(DIGITS); j++) begin
      w_adj[4*j +: 4] = bcd_add3(r_scratch[4*j +: 4]);
    end
  end

  assign w_shifted = BCD_W'({w_adj, r_bin[IN_W-1]});

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_busy  <= (w_state_next == CONVERT);
      r_valid <= (w_state_next == DONE);
      if (w_accept) begin
        r_bin     <= count_in;
        r_scratch <= '0;
        r_cnt     <= '0;
      end else if (r_state == CONVERT) begin
        r_bin     <= r_bin << 1;
        r_scratch <= w_shifted;
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      if (w_commit) r_bcd <= w_shifted;
    end
  end

  // Lets the display pick up a commit on the same edge it advances digits.
  assign bcd_next_c = w_commit ? w_shifted : r_bcd;

  assign busy      = r_busy;
  assign bcd_valid = r_valid;
  assign bcd_out   = r_bcd;

endmodule

// File: rtl/count_bcd_display.sv
// Counter snapshot -> BCD -> multiplexed seven-segment display.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned SCAN_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       count_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BCD_W-1:0]    w_bcd_next;
  logic [SCAN_DIV-1:0] r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_next;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg_next;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_digit_sel;

  bcd_double_dabble #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) u_dd (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_in   (count_in),
    .load       (load),
    .busy       (busy),
    .bcd_valid  (bcd_valid),
    .bcd_out    (bcd_out),
    .bcd_next_c (w_bcd_next)
  );

  always_comb begin
    w_idx_next = r_idx;
    if (&r_presc) begin
      w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_comb begin
    w_nib = '0;
    for (int j = 0; j < int'(DIGITS); j++) begin
      if (w_idx_next == IDX_W'(j)) w_nib = w_bcd_next[4*j +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_zero_from;

  // w_zero_from[j]: digit j and every digit above it are zero.
  always_comb begin
    w_zero_from = '0;
    w_zero_from[DIGITS-1] = (w_bcd_next[BCD_W-1 -: 4] == 4'd0);
    for (int j = int'(DIGITS) - 2; j >= 0; j--) begin
      w_zero_from[j] = w_zero_from[j+1] && (w_bcd_next[4*j +: 4] == 4'd0);
    end
  end

  always_comb begin
    w_seg_next = seg_glyph(w_nib);
    for (int j = 1; j < int'(DIGITS); j++) begin
      if (w_idx_next == IDX_W'(j) && w_zero_from[j]) w_seg_next = SEG_BLANK;
    end
  end
`else
  always_comb begin
    w_seg_next = seg_glyph(w_nib);
  end
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_seg       <= SEG_0;
      r_digit_sel <= DIGITS'(1);
    end else begin
      r_presc     <= r_presc + SCAN_DIV'(1);
      r_idx       <= w_idx_next;
      r_seg       <= w_seg_next;
      r_digit_sel <= DIGITS'(1) << w_idx_next;
    end
  end

  assign seg       = r_seg;
  assign digit_sel = r_digit_sel;

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display (SCAN_DIV=4); honours LEADING_ZERO_BLANK_EN.
module tb_count_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] count_in;
  logic        load;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd_out;
  logic [6:0]  seg;
  logic [4:0]  digit_sel;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] v;
    logic [19:0] e;
  } vec_t;

  vec_t vecs[8];

  count_bcd_display #(
    .IN_W     (16),
    .DIGITS   (5),
    .SCAN_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_in  (count_in),
    .load      (load),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .bcd_out   (bcd_out),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [19:0] v, input int idx);
    logic [19:0] sh;
    sh = v >> (4 * idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && sh == 20'd0) return 7'h00;
`endif
    return glyph(sh[3:0]);
  endfunction

  // Called at #1 after an edge; that edge is edge k of the conversion.
  task automatic pulse_load(input logic [15:0] v);
    count_in = v;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    check("busy_after_load", 32'(busy), 32'd1);
  endtask

  // Expects to be called at #1 after edge k; returns at #1 after edge k+16.
  task automatic expect_result(input logic [19:0] e);
    int nb = 0;
    int nv = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy) nb++;
      if (bcd_valid) nv++;
      tick();
    end
    check("busy_cycles", 32'(nb), 32'd16);
    check("valid_early", 32'(nv), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    check("valid_pulse", 32'(bcd_valid), 32'd1);
    check("bcd_out", 32'(bcd_out), 32'(e));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'h3F);
    check({tag, "_digit_sel"}, 32'(digit_sel), 32'h01);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(bcd_valid), 32'd0);
    check({tag, "_bcd_out"}, 32'(bcd_out), 32'd0);
  endtask

  // Watches the scanner for ncyc cycles: seg vs active digit, order and dwell time.
  task automatic scan_check(input logic [19:0] v, input int ncyc);
    logic [4:0] prev;
    int run = 0;
    int changes = 0;
    int idx;
    prev = digit_sel;
    for (int c = 0; c < ncyc; c++) begin
      idx = -1;
      for (int i = 0; i < 5; i++) if (digit_sel[i]) idx = i;
      if (!$onehot(digit_sel) || idx < 0) begin
        check("scan_onehot", 32'(digit_sel), 32'h0);
      end else begin
        check("scan_seg", 32'(seg), 32'(exp_seg(v, idx)));
      end
      if (digit_sel != prev) begin
        check("scan_order", 32'(digit_sel), 32'((prev == 5'b10000) ? 5'b00001 : (prev << 1)));
        if (changes > 0) check("scan_dwell", 32'(run), 32'd16);
        changes++;
        run = 0;
      end
      run++;
      prev = digit_sel;
      tick();
    end
    check("scan_advanced", 32'(changes >= 5), 32'd1);
  endtask

  initial begin
    int nv;
    vecs[0] = '{16'd12345, 20'h12345};
    vecs[1] = '{16'd65535, 20'h65535};
    vecs[2] = '{16'd0,     20'h00000};
    vecs[3] = '{16'd9999,  20'h09999};
    vecs[4] = '{16'd10000, 20'h10000};
    vecs[5] = '{16'd59999, 20'h59999};
    vecs[6] = '{16'd42,    20'h00042};
    vecs[7] = '{16'd1,     20'h00001};

    rst_n    = 1'b1;
    count_in = '0;
    load     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_reset_state("reset");
    tick();

    // Table-driven conversions.
    for (int t = 0; t < 8; t++) begin
      pulse_load(vecs[t].v);
      expect_result(vecs[t].e);
      tick();
      check("valid_single", 32'(bcd_valid), 32'd0);
      check("bcd_hold", 32'(bcd_out), 32'(vecs[t].e));
    end

    // Scan of 12345.
    pulse_load(16'd12345);
    expect_result(20'h12345);
    scan_check(20'h12345, 100);

    // Back-to-back: reload while in DONE.
    pulse_load(16'd65535);
    expect_result(20'h65535);
    pulse_load(16'd0);
    check("b2b_valid_low", 32'(bcd_valid), 32'd0);
    expect_result(20'h00000);
    tick();

    // Load while busy is ignored.
    pulse_load(16'd100);
    repeat (4) tick();
    count_in = 16'd999;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (bcd_valid) nv++;
      tick();
    end
    check("ignore_valid_count", 32'(nv), 32'd1);
    check("ignore_bcd_out", 32'(bcd_out), 32'h00100);

    // Reset mid-conversion.
    pulse_load(16'd54321);
    repeat (7) tick();
    rst_n = 1'b1;
    #2;
    check_reset_state("midreset");
    @(negedge clk) rst_n = 1'b0;
    tick();
    pulse_load(16'd7);
    expect_result(20'h00007);
    tick();

    // Leading-zero display of 42.
    pulse_load(16'd42);
    expect_result(20'h00042);
    scan_check(20'h00042, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
